regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised two-read/one-write register file for the MIPS datapath; successor to the fixed 32x32 file.
//  Adds synchronous reset, a hardware clear sequencer, optional hardwired-zero register 0 and optional write-to-read bypass.
//  Sits between the decode stage (read ports) and the writeback stage (write port).
//  Reports writes lost while the clear sequencer is running.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W registers
//  ZERO_REG  1   1: register 0 always reads 0 and ignores writes; 0: register 0 is ordinary storage
//  BYPASS    1   1: a read of the address being written this cycle returns wr_data; 0: returns old contents
// PORTS
//  clk       in   1       clock; all state updates on posedge
//  rst_n     in   1       synchronous reset, active low
//  clr_req   in   1       request a full clear of all registers (sampled only in READY)
//  rd_addr1  in   ADDR_W  read port 1 address
//  rd_data1  out  DATA_W  read port 1 data (combinational)
//  rd_addr2  in   ADDR_W  read port 2 address
//  rd_data2  out  DATA_W  read port 2 data (combinational)
//  wr_en     in   1       write enable
//  wr_addr   in   ADDR_W  write address
//  wr_data   in   DATA_W  write data
//  busy      out  1       1 while the clear sequencer runs; register file unusable
//  wr_drop   out  1       registered 1-cycle pulse: a write was discarded in the previous cycle
// BEHAVIOUR
//  Reset: rst_n low at a posedge -> state INIT, clr_cnt=0, busy=1, wr_drop=0. Reset has priority over all else.
//  Reset does not clear storage directly; the INIT walk does. Reset mid-INIT restarts the walk at address 0.
//  FSM states: INIT, READY.
//   INIT: each posedge writes 0 to mem[clr_cnt] and increments clr_cnt (ADDR_W bits).
//         When clr_cnt==DEPTH-1 the write is performed and state -> READY; clr_cnt wraps to 0.
//         busy is 1 for exactly DEPTH posedges after the first posedge with rst_n high.
//   READY: busy=0. clr_req=1 -> state INIT, clr_cnt=0 at next posedge; a wr_en in that cycle is discarded.
//         clr_req=0: wr_en=1 writes mem[wr_addr]<=wr_data at posedge, except wr_addr==0 with ZERO_REG=1 (silently ignored, not a drop).
//  Write drop: wr_en=1 while in INIT, or wr_en=1 concurrent with an accepted clr_req -> wr_drop=1 on the following cycle only.
//   Otherwise wr_drop=0 next cycle. Ignored writes to reg 0 never set wr_drop.
//  Reads (each port independently, priority order):
//   busy=1 -> 0; ZERO_REG=1 and addr==0 -> 0;
//   BYPASS=1 and wr_en=1 and addr==wr_addr and the write is valid this cycle (READY, clr_req=0) -> wr_data;
//   else mem[addr].
//  Both read ports may address the same register, including the write target; both return identical data.
//  No latency on reads; write visible on the read ports the cycle after the posedge (or same cycle with BYPASS).
//  clr_req held high continuously: re-enters INIT after each completed walk (busy drops for one cycle between walks).
//  Storage contents are undefined only before the first completed INIT walk; reads are 0 during it anyway.
// TESTING (defaults unless stated)
//  1 Reset: rst_n=0 two cycles then 1 -> busy=1 for exactly 32 posedges then 0; all 32 registers read 0x00000000.
//  2 Write/read: wr_en=1 wr_addr=3 wr_data=0x11111113, next cycle rd_addr1=3 -> rd_data1=0x11111113; rd_addr2=3 same value.
//  3 Bypass: same-cycle wr_addr=rd_addr1=7, wr_data=0xDEADBEEF -> rd_data1=0xDEADBEEF combinationally; BYPASS=0 -> old value 0.
//  4 Zero reg: write 0xFFFFFFFF to addr 0 -> rd_data=0, wr_drop=0; with ZERO_REG=0 -> reads 0xFFFFFFFF.
//  5 Clear: load reg 4=0x11111114, pulse clr_req with wr_en=1 addr 5 -> wr_drop=1 next cycle, busy 32 cycles, reg 4 and 5 read 0.
//  6 Reset mid-INIT: assert rst_n=0 at clr_cnt=10, release -> busy restarts, lasts full 32 cycles; write during INIT -> wr_drop=1.

Source files
------------

// File: rtl/regfile_param.sv
// Two-read/one-write register file with a hardware clear walk, optional
// hardwired-zero register 0 and optional write-to-read bypass.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_valid;
  logic              wr_commit;
  logic              wr_lost;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // A write is valid only in READY with no clear being accepted; a valid
  // write to a hardwired-zero register 0 is silently ignored, not dropped.
  assign wr_valid  = (state_q == READY) && !clr_req && wr_en;
  assign wr_commit = wr_valid && !(ZERO_REG && (wr_addr == '0));
  assign wr_lost   = wr_en && ((state_q == INIT) || clr_req);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_drop_d = wr_lost;
    case (state_q)
      INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (clr_req) begin
          state_d   = INIT;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = INIT;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // The clear walk and the writeback port share the single storage write port.
  assign mem_we    = (state_q == INIT) || wr_commit;
  assign mem_waddr = (state_q == INIT) ? clr_cnt_q : wr_addr;
  assign mem_wdata = (state_q == INIT) ? '0 : wr_data;

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] data;
    if (state_q == INIT) begin
      data = '0;
    end else if (ZERO_REG && (addr == '0)) begin
      data = '0;
    end else if (BYPASS && wr_valid && (addr == wr_addr)) begin
      data = wr_data;
    end else begin
      data = mem_q[addr];
    end
    return data;
  endfunction

  assign rd_data1 = read_port(rd_addr1);
  assign rd_data2 = read_port(rd_addr2);
  assign busy     = (state_q == INIT);
  assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a default instance and a ZERO_REG=0/BYPASS=0 instance
// share stimulus and are checked against a behavioural register-file model.
module tb_regfile_param;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clr_req, wr_en;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data1, rd_data2, a_rd_data1, a_rd_data2;
  logic        busy, wr_drop, a_busy, a_wr_drop;

  int checks = 0;
  int errors = 0;

  regfile_param dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1),
    .rd_addr2(rd_addr2), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .wr_drop(wr_drop)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_alt (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .rd_addr1(rd_addr1), .rd_data1(a_rd_data1),
    .rd_addr2(rd_addr2), .rd_data2(a_rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(a_busy), .wr_drop(a_wr_drop)
  );

  // Reference model: index 0 = default instance, index 1 = alternate instance.
  logic [31:0] m_mem [2][DEPTH];
  bit          m_busy = 1'b1;
  int          m_walk = 0;
  bit          m_drop = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b1;
      m_walk = 0;
      m_drop = 1'b0;
    end else if (m_busy) begin
      m_drop = wr_en;
      for (int k = 0; k < 2; k++) m_mem[k][m_walk] = 32'h0;
      m_walk++;
      if (m_walk == DEPTH) begin
        m_busy = 1'b0;
        m_walk = 0;
      end
    end else if (clr_req) begin
      m_drop = wr_en;
      m_busy = 1'b1;
      m_walk = 0;
    end else begin
      m_drop = 1'b0;
      if (wr_en) begin
        if (wr_addr != 5'd0) m_mem[0][wr_addr] = wr_data;
        m_mem[1][wr_addr] = wr_data;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input int inst, input logic [4:0] a);
    if (m_busy) return 32'h0;
    if (inst == 0 && a == 5'd0) return 32'h0;
    if (inst == 0 && wr_en && !clr_req && a == wr_addr) return wr_data;
    return m_mem[inst][a];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; clr_req = 1'b0; wr_en = 1'b0;
    wr_addr = 5'd0; wr_data = 32'h0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    step(); step();
    checks++;
    if ({busy, wr_drop, a_busy, a_wr_drop} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_state: got busy/drop/abusy/adrop=%b expected 1010",
               {busy, wr_drop, a_busy, a_wr_drop});
    end
    rst_n = 1'b1;
    n = 0;
    do begin step(); n++; end while (busy === 1'b1 && n < 100);
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL reset_busy_len: got %0d posedges expected 32", n);
    end
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_alt_busy: got %b expected 0", a_busy);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(DEPTH - 1 - a);
      #1;
      checks++;
      if ({rd_data1, rd_data2, a_rd_data1, a_rd_data2} !== 128'h0) begin
        errors++;
        $display("FAIL reset_clear_reg%0d: got %h %h %h %h expected all zero",
                 a, rd_data1, rd_data2, a_rd_data1, a_rd_data2);
      end
    end
  endtask

  task automatic test_write_read();
    step();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11111113;
    step();
    wr_en = 1'b0; rd_addr1 = 5'd3; rd_addr2 = 5'd3;
    #1;
    checks++;
    if ({rd_data1, rd_data2} !== {2{32'h11111113}}) begin
      errors++;
      $display("FAIL write_read: got %h %h expected 11111113", rd_data1, rd_data2);
    end
    checks++;
    if ({a_rd_data1, a_rd_data2} !== {2{32'h11111113}}) begin
      errors++;
      $display("FAIL write_read_alt: got %h %h expected 11111113", a_rd_data1, a_rd_data2);
    end
    checks++;
    if ({wr_drop, a_wr_drop} !== 2'b00) begin
      errors++;
      $display("FAIL write_read_drop: got %b expected 00", {wr_drop, a_wr_drop});
    end
  endtask

  task automatic test_bypass();
    step();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    rd_addr1 = 5'd7; rd_addr2 = 5'd7;
    #1;
    checks++;
    if ({rd_data1, rd_data2} !== {2{32'hDEADBEEF}}) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h %h expected deadbeef", rd_data1, rd_data2);
    end
    checks++;
    if (a_rd_data1 !== 32'h0) begin
      errors++;
      $display("FAIL nobypass_old: got %h expected 00000000", a_rd_data1);
    end
    step();
    wr_en = 1'b0;
    #1;
    checks++;
    if ({a_rd_data1, rd_data1} !== {2{32'hDEADBEEF}}) begin
      errors++;
      $display("FAIL bypass_after: got %h %h expected deadbeef", a_rd_data1, rd_data1);
    end
  endtask

  task automatic test_zero_reg();
    step();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    #1;
    checks++;
    if ({rd_data1, a_rd_data1} !== 64'h0) begin
      errors++;
      $display("FAIL zero_same_cycle: got %h %h expected 0 0", rd_data1, a_rd_data1);
    end
    step();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg_read: got %h %h expected 0", rd_data1, rd_data2);
    end
    checks++;
    if (a_rd_data1 !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL zero_reg_plain: got %h expected ffffffff", a_rd_data1);
    end
    checks++;
    if ({wr_drop, a_wr_drop} !== 2'b00) begin
      errors++;
      $display("FAIL zero_reg_drop: got %b expected 00", {wr_drop, a_wr_drop});
    end
  endtask

  task automatic test_random(input int n, input int clr_pct, input int rst_pct);
    logic [131:0] got, exp;
    for (int i = 0; i < n; i++) begin
      step();
      rst_n    = !(rst_pct > 0 && $urandom_range(0, 99) < rst_pct);
      clr_req  = (clr_pct > 0 && $urandom_range(0, 99) < clr_pct);
      wr_en    = ($urandom_range(0, 3) != 0);
      wr_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr2 = ($urandom_range(0, 3) == 0) ? rd_addr1 : 5'($urandom_range(0, 31));
      @(negedge clk);
      got = {rd_data1, rd_data2, a_rd_data1, a_rd_data2, busy, a_busy, wr_drop, a_wr_drop};
      exp = {exp_rd(0, rd_addr1), exp_rd(0, rd_addr2), exp_rd(1, rd_addr1), exp_rd(1, rd_addr2),
             m_busy, m_busy, m_drop, m_drop};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, got, exp);
      end
    end
    rst_n = 1'b1; clr_req = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_clear();
    int n;
    step();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h11111114;
    step();
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55555555;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_pre_busy: got %b expected 0", busy);
    end
    step();
    clr_req = 1'b0; wr_en = 1'b0;
    checks++;
    if ({wr_drop, a_wr_drop, busy, a_busy} !== 4'b1111) begin
      errors++;
      $display("FAIL clear_drop: got drop/adrop/busy/abusy=%b expected 1111",
               {wr_drop, a_wr_drop, busy, a_busy});
    end
    n = 0;
    do begin step(); n++; end while (busy === 1'b1 && n < 100);
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL clear_busy_len: got %0d expected 32", n);
    end
    rd_addr1 = 5'd4; rd_addr2 = 5'd5;
    #1;
    checks++;
    if ({rd_data1, rd_data2, a_rd_data1, a_rd_data2, wr_drop} !== 129'h0) begin
      errors++;
      $display("FAIL clear_regs: got %h %h %h %h drop %b expected zeros",
               rd_data1, rd_data2, a_rd_data1, a_rd_data2, wr_drop);
    end
  endtask

  task automatic test_reset_mid_init();
    int n;
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 5) begin
        checks++;
        if ({wr_drop, a_wr_drop} !== 2'b11) begin
          errors++;
          $display("FAIL init_write_drop: got %b expected 11", {wr_drop, a_wr_drop});
        end
      end
      wr_en = (i == 4);
      wr_addr = 5'd9; wr_data = 32'h99999999;
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({busy, wr_drop} !== 2'b10) begin
      errors++;
      $display("FAIL midinit_reset_state: got busy/drop=%b expected 10", {busy, wr_drop});
    end
    n = 0;
    do begin step(); n++; end while (busy === 1'b1 && n < 100);
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL midinit_busy_len: got %0d expected 32", n);
    end
    rd_addr1 = 5'd9; rd_addr2 = 5'd4;
    #1;
    checks++;
    if ({rd_data1, a_rd_data1, a_rd_data2} !== {exp_rd(0, 5'd9), exp_rd(1, 5'd9), exp_rd(1, 5'd4)}) begin
      errors++;
      $display("FAIL midinit_regs: got %h %h %h expected model values",
               rd_data1, a_rd_data1, a_rd_data2);
    end
  endtask

  task automatic test_clr_held();
    int lows;
    int n;
    lows = 0;
    clr_req = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (busy === 1'b0) lows++;
      checks++;
      if ({busy, a_busy} !== {2{m_busy}}) begin
        errors++;
        $display("FAIL clr_held_cycle%0d: got %b expected %b", i, {busy, a_busy}, {2{m_busy}});
      end
    end
    checks++;
    if (lows != 3) begin
      errors++;
      $display("FAIL clr_held_gaps: got %0d ready cycles expected 3", lows);
    end
    clr_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_held_release: got busy %b expected 0", busy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_random(200, 0, 0);
    test_clear();
    test_reset_mid_init();
    test_clr_held();
    test_random(400, 3, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
